// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver, so that both
// sides take their bit period from a single constant.
package uart_pkg;

  localparam int BAUD_DIV_DFLT = 5208;
  localparam int DATA_BITS     = 8;
  // bit_cnt value at the stop-bit midpoint (start = 0, data = 1..8)
  localparam logic [3:0] STOP_IDX = 4'd9;

  typedef enum logic {
    IDLE,
    RECEIVING
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Serial line plus parallel byte handshake between uart_rx and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 RX;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 frm_err;

  modport slave  (input  RX, clr_rdy, output rx_data, rdy, frm_err);
  modport master (output RX, clr_rdy, input  rx_data, rdy, frm_err);

endinterface : uart_rx_if

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset
// value is parameterised so an idle-high line comes out of reset as idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // NOTE: clocked state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, forming a real 2-stage chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises RX, finds the start edge, samples each
// bit at its midpoint and presents the byte with rdy / frm_err flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DFLT,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);

  logic rx_s2;
  logic rx_s3_q;
  logic start_det;
  logic sample;

  rx_state_t            state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q,     rdy_d;
  logic                 frm_err_q, frm_err_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.RX),
    .q_o (rx_s2)
  );

  // Only a fresh 1->0 transition starts a frame; a line held low does not.
  assign start_det = rx_s3_q & ~rx_s2;
  assign sample    = (state_q == RECEIVING) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s3_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_s3_q   <= rx_s2;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    frm_err_d = frm_err_q;

    // Acknowledge first, so a flag set later in this cycle takes priority.
    if (bus.clr_rdy) begin
      rdy_d     = 1'b0;
      frm_err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d   = RECEIVING;
          cnt_d     = HALF_LOAD;
          bit_cnt_d = '0;
          rdy_d     = 1'b0;
          frm_err_d = 1'b0;
        end
      end

      RECEIVING: begin
        if (sample) begin
          cnt_d     = BAUD_LOAD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (rx_s2) state_d = IDLE;
          end else if (bit_cnt_q < STOP_IDX) begin
            shreg_d = {rx_s2, shreg_q[DATA_BITS-1:1]};
          end else begin
            state_d = IDLE;
            if (rx_s2) begin
              rx_data_d = shreg_q;
              rdy_d     = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged 8N1 frames with a short bit period,
// hand-computed expected bytes, flags and stop-sample timing.
module tb_uart_rx;

  localparam int BAUD  = 16;
  localparam int HALF  = BAUD / 2;
  localparam int FRAME = 10 * BAUD;
  localparam int LAT   = 2 + HALF + 9 * BAUD;   // nominal rdy latency, +/-1
  localparam int STOP_EDGE = LAT + 1;           // 2 sync flops + start_det register

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if bus_if ();

  uart_rx #(.BAUD_DIV(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int          rdy_cycle;
  logic [7:0]  rx_at_rdy;
  logic        frm_at_rdy;
  logic [7:0]  snap_data;
  logic        snap_rdy;
  logic        snap_frm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n, input logic level);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.RX      = level;
      bus_if.clr_rdy = 1'b0;
    end
  endtask

  // One frame, iteration c at the negedge after c posedges from the start fall.
  // clr_at / rst_at pulse those inputs across the following posedge (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int clr_at, input int rst_at);
    logic [9:0] frame;
    logic       prev;
    frame     = {stop_bit, d, 1'b0};
    prev      = 1'b1;
    rdy_cycle = -1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (bus_if.rdy && !prev && rdy_cycle < 0) begin
        rdy_cycle  = c;
        rx_at_rdy  = bus_if.rx_data;
        frm_at_rdy = bus_if.frm_err;
      end
      prev = bus_if.rdy;
      if (rst_at >= 0 && c == rst_at + 1) begin
        snap_data = bus_if.rx_data;
        snap_rdy  = bus_if.rdy;
        snap_frm  = bus_if.frm_err;
      end
      bus_if.RX      = frame[c / BAUD];
      bus_if.clr_rdy = (c == clr_at);
      rst            = (c == rst_at);
    end
  endtask

  initial begin
    logic in_win;
    bus_if.RX      = 1'b1;
    bus_if.clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus_if.rx_data, 8'h00);
    check("reset_rdy",     bus_if.rdy,     1'b0);
    check("reset_frm_err", bus_if.frm_err, 1'b0);
    rst = 1'b0;
    idle(BAUD, 1'b1);

    // Basic frame and latency window
    send_frame(8'hA5, 1'b1, -1, -1);
    in_win = (rdy_cycle >= LAT - 1) && (rdy_cycle <= LAT + 1);
    check("a5_latency_ok", in_win,     1'b1);
    check("a5_data",       rx_at_rdy,  8'hA5);
    check("a5_frm_err",    frm_at_rdy, 1'b0);
    check("a5_rdy_held",   bus_if.rdy, 1'b1);

    // Data extremes back-to-back, zero gap, acknowledged after each
    send_frame(8'h00, 1'b1, STOP_EDGE + 2, -1);
    check("x00_data",    rx_at_rdy,  8'h00);
    check("x00_frm_err", frm_at_rdy, 1'b0);
    check("x00_cleared", bus_if.rdy, 1'b0);
    send_frame(8'hFF, 1'b1, STOP_EDGE + 2, -1);
    check("xff_data",    rx_at_rdy,  8'hFF);
    check("xff_frm_err", frm_at_rdy, 1'b0);
    check("xff_cleared", bus_if.rdy, 1'b0);

    // Glitch shorter than half a bit is rejected at the start midpoint
    idle(4, 1'b0);
    idle(2 * FRAME, 1'b1);
    check("glitch_rdy",     bus_if.rdy,     1'b0);
    check("glitch_frm_err", bus_if.frm_err, 1'b0);
    check("glitch_data",    bus_if.rx_data, 8'hFF);

    // Framing error, then a line held low must not retrigger
    send_frame(8'h3C, 1'b0, -1, -1);
    check("ferr_flag", bus_if.frm_err, 1'b1);
    check("ferr_rdy",  bus_if.rdy,     1'b0);
    check("ferr_data", bus_if.rx_data, 8'hFF);
    idle(3 * BAUD, 1'b0);
    check("ferr_no_rearm", bus_if.frm_err, 1'b1);
    idle(BAUD, 1'b1);
    send_frame(8'h11, 1'b1, -1, -1);
    check("x11_seen",    rdy_cycle >= 0, 1'b1);
    check("x11_data",    rx_at_rdy,      8'h11);
    check("x11_frm_err", frm_at_rdy,     1'b0);
    check("x11_rdy",     bus_if.rdy,     1'b1);

    // clr_rdy on the stop-sample edge loses to the set; one later clears
    send_frame(8'h22, 1'b1, STOP_EDGE - 1, -1);
    check("coll_same_rdy",  bus_if.rdy,     1'b1);
    check("coll_same_data", bus_if.rx_data, 8'h22);
    send_frame(8'h33, 1'b1, STOP_EDGE, -1);
    check("coll_late_seen", rdy_cycle,      STOP_EDGE);
    check("coll_late_rdy",  bus_if.rdy,     1'b0);
    check("coll_late_data", bus_if.rx_data, 8'h33);

    // Reset pulse mid data bit 4 of 0xC3
    send_frame(8'hC3, 1'b1, -1, 5 * BAUD + HALF);
    check("rst_rx_data", snap_data, 8'h00);
    check("rst_rdy",     snap_rdy,  1'b0);
    check("rst_frm_err", snap_frm,  1'b0);
    check("rst_no_rdy",  rdy_cycle, 32'hFFFF_FFFF);
    idle(2 * FRAME, 1'b1);
    @(negedge clk);
    bus_if.clr_rdy = 1'b1;
    idle(BAUD, 1'b1);
    send_frame(8'h5A, 1'b1, -1, -1);
    check("x5a_data",    rx_at_rdy,  8'h5A);
    check("x5a_frm_err", frm_at_rdy, 1'b0);
    check("x5a_rdy",     bus_if.rdy, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream stage of the UART transmitter.
- Accepts the 8N1 line driven by the transmitter's TX output, 1 start, 8 data LSB-first, 1 stop, idle high.
- Samples each bit at its midpoint and presents the byte in parallel with a ready flag.
- Used on the FPGA receive path and in transmitter loopback tests.

Parameters:
- BAUD_DIV, 5208: clocks per bit period; must match the transmitter's bit period (5207 terminal count + 1).
- HALF_DIV, BAUD_DIV/2 = 2604: clocks from start-bit falling edge to start-bit midpoint.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial line; idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy and frm_err.
- rx_data  output  8  last correctly framed byte.
- rdy  output  1  new byte available in rx_data.
- frm_err  output  1  last frame had a stop bit of 0.

Behaviour:
- Reset is synchronous, active-high, single clock clk.
- Reset values:
  - rx_data = 8'h00, rdy = 0, frm_err = 0.
  - Sync flops = 1, state = IDLE, counters = 0.
- Synchroniser:
  - RX passes through 2 flops (rx_s1, rx_s2) plus a third flop rx_s3 for edge detection.
  - start_det = rx_s3 & ~rx_s2 (falling edge).
- Baud counter:
  - Down-counter, width $clog2(BAUD_DIV).
  - sample strobe when count == 0 in RECEIVING.
  - Loads HALF_DIV-1 on start_det; reloads BAUD_DIV-1 on every sample.
- bit_cnt: 4 bits; cleared on start_det; increments on each sample, counting 0..9.
- States:
  - IDLE: on start_det, go to RECEIVING, load counters, clear rdy and frm_err.
  - RECEIVING, sample with bit_cnt==0 (start-bit midpoint):
    - rx_s2==1 (false start/glitch): return to IDLE; no flag change.
  - RECEIVING, sample with bit_cnt 1..8:
    - Shift rx_s2 into the MSB of the 8-bit shift register (shreg <= {rx_s2, shreg[7:1]}).
  - RECEIVING, sample with bit_cnt==9 (stop-bit midpoint):
    - rx_s2==1: rx_data <= shreg, rdy <= 1, go to IDLE.
    - rx_s2==0: frm_err <= 1, rx_data unchanged, rdy stays 0, go to IDLE.
- Re-arm: in IDLE, start detection needs a fresh 1->0 edge.
  - A line held low after a framing error does not retrigger.
- Latency: rdy rises 2 + HALF_DIV + 9*BAUD_DIV clocks (+/-1) after RX falls.
  - Default: 49,478 clocks, about mid stop bit.
- rdy / frm_err clearing:
  - Cleared by clr_rdy, or by start_det of the next frame.
  - Set and clr_rdy in the same cycle: set wins.
- Back-to-back frames: the next start edge is accepted in the cycle after the return to IDLE.
  - This allows a zero-gap stream from the transmitter.
- rst asserted mid-frame: abort immediately to reset values; partial byte discarded.
- RX changes are never used unsynchronised; only rx_s2/rx_s3 feed logic.

Decomposition:
- Package uart_pkg holds:
  - localparam BAUD_DIV_DFLT = 5208.
  - typedef enum logic {IDLE, RECEIVING} rx_state_t.
  - uart_pkg is shared with the transmitter to keep the bit period single-sourced.
- Sub-module sync_2ff: 2-flop synchroniser with parameterised reset value 1'b1; uart_rx instantiates one.
- Everything else stays flat in uart_rx.

Test Plan:
- Loopback, basic: transmitter TX -> RX, send 8'hA5.
  - rdy=1 with rx_data=8'hA5 within 49,480 clocks of trmt; frm_err=0.
- Loopback, data extremes: send 8'h00 then 8'hFF back-to-back, clr_rdy pulsed after each.
  - Two rdy events with 8'h00 then 8'hFF; no frm_err.
- Glitch rejection: drive RX low for 1000 clocks, then high.
  - FSM returns to IDLE at the start midpoint; rdy=0, frm_err=0, rx_data unchanged.
- Framing error: bit-bang 8'h3C with stop bit = 0.
  - frm_err=1, rdy=0, rx_data keeps its previous value (8'hFF).
  - A following good frame 8'h11 gives rdy=1, frm_err=0, rx_data=8'h11.
- Set/clear collision: assert clr_rdy in the exact cycle of the stop sample -> rdy=1.
  - clr_rdy one cycle later -> rdy=0.
- Reset mid-frame: assert rst for 1 clock during data bit 4 of 8'hC3.
  - All outputs are reset values the next cycle.
  - No rdy from the aborted frame; the next clean frame 8'h5A is received correctly.
